// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter
//
// Picks which of the seven DMA channels (MDECin, MDECout, GPU, CDROM, SPU, PIO, OTC)
// owns the shared RAM bus. The choice uses the DPCR priority and master-enable fields.
// When chopping is enabled, the granted channel runs a burst of 2^dma_win words. The bus
// then goes back to the CPU for 2^cpu_win cycles before the channels are arbitrated again.
//
// Optional build macro: DMA_ARB_ROUND_ROBIN_EN
//   undefined : ties between equal priorities go to the highest channel index.
//   defined   : ties are broken round-robin from a last-grant pointer (reset value 6).
//
// Ports:
//   i_clk, i_nrst   clock and asynchronous active-low reset
//   i_req           per-channel request
//   i_master_en     DPCR per-channel master enable
//   i_priority      DPCR priority, 3 bits per channel, 0 is highest
//   i_chop_en       CHCR chopping enable per channel
//   i_dma_win       CHCR DMA window exponent per channel
//   i_cpu_win       CHCR CPU window exponent per channel
//   i_word_ack      granted channel moved one word this cycle
//   i_ch_done       granted channel finished its transfer
//   o_grant         registered one-hot grant
//   o_grant_id      binary id of the granted channel (valid while o_bus_dma)
//   o_bus_dma       DMA owns the bus
//   o_cpu_window    chopping CPU window in progress
module dma_channel_arbiter #(
    parameter int NCH   = 7,
    parameter int WIN_W = 3,
    parameter int CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic [NCH-1:0]       i_req,
    input  logic [NCH-1:0]       i_master_en,
    input  logic [3*NCH-1:0]     i_priority,
    input  logic [NCH-1:0]       i_chop_en,
    input  logic [WIN_W*NCH-1:0] i_dma_win,
    input  logic [WIN_W*NCH-1:0] i_cpu_win,
    input  logic                 i_word_ack,
    input  logic                 i_ch_done,
    output logic [NCH-1:0]       o_grant,
    output logic [2:0]           o_grant_id,
    output logic                 o_bus_dma,
    output logic                 o_cpu_window
);

    typedef enum logic [1:0] {StIdle, StGrant, StCpuWin} state_e;

    state_e           state;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cpu_cnt;
    logic [NCH-1:0]   elig;
    logic [2:0]       win_id;

`ifdef DMA_ARB_ROUND_ROBIN_EN
    logic [2:0]       rr_ptr;
`endif

    assign elig      = i_req & i_master_en;
    assign o_bus_dma = |o_grant;

    // Winner selection: lowest priority value wins.
    always_comb begin : pick_winner
        logic [2:0] best_prio;
        logic       found;
        int         idx;
        win_id    = '0;
        best_prio = '1;
        found     = 1'b0;
        idx       = 0;
`ifdef DMA_ARB_ROUND_ROBIN_EN
        // Scan from the index just above the last grant. A strict '<' keeps the first
        // equal-priority channel in that order.
        for (int o = 1; o <= NCH; o++) begin
            idx = (int'(rr_ptr) + o) % NCH;
            if (elig[idx] && (!found || i_priority[3*idx +: 3] < best_prio)) begin
                found     = 1'b1;
                best_prio = i_priority[3*idx +: 3];
                win_id    = 3'(idx);
            end
        end
`else
        // Ascending scan. '<=' lets a later (higher) index take a tie.
        for (int k = 0; k < NCH; k++) begin
            if (elig[k] && (!found || i_priority[3*k +: 3] <= best_prio)) begin
                found     = 1'b1;
                best_prio = i_priority[3*k +: 3];
                win_id    = 3'(k);
            end
        end
`endif
    end

    // Fields of the currently granted channel, sampled live.
    logic             g_alive;
    logic             g_chop;
    logic [WIN_W-1:0] g_dma_win;
    logic [WIN_W-1:0] g_cpu_win;
    logic [CNT_W-1:0] burst_next;
    logic [CNT_W-1:0] dma_len;
    logic [CNT_W-1:0] cpu_len;

    assign g_alive    = i_req[o_grant_id] & i_master_en[o_grant_id];
    assign g_chop     = i_chop_en[o_grant_id];
    assign g_dma_win  = i_dma_win[WIN_W*o_grant_id +: WIN_W];
    assign g_cpu_win  = i_cpu_win[WIN_W*o_grant_id +: WIN_W];
    assign burst_next = burst_cnt + CNT_W'(1);
    assign dma_len    = CNT_W'(1) << g_dma_win;
    assign cpu_len    = CNT_W'(1) << g_cpu_win;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state        <= StIdle;
            o_grant      <= '0;
            o_grant_id   <= '0;
            o_cpu_window <= 1'b0;
            burst_cnt    <= '0;
            cpu_cnt      <= '0;
`ifdef DMA_ARB_ROUND_ROBIN_EN
            rr_ptr       <= 3'd6;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (|elig) begin
                        o_grant    <= NCH'(1) << win_id;
                        o_grant_id <= win_id;
                        burst_cnt  <= '0;
                        state      <= StGrant;
`ifdef DMA_ARB_ROUND_ROBIN_EN
                        rr_ptr     <= win_id;
`endif
                    end
                end
                StGrant: begin
                    // Done and abort both drop the grant without a CPU window.
                    if (i_ch_done || !g_alive) begin
                        o_grant <= '0;
                        state   <= StIdle;
                    end else if (i_word_ack) begin
                        burst_cnt <= burst_next;
                        if (g_chop && burst_next == dma_len) begin
                            o_grant      <= '0;
                            cpu_cnt      <= cpu_len;
                            o_cpu_window <= 1'b1;
                            state        <= StCpuWin;
                        end
                    end
                end
                StCpuWin: begin
                    // The window is high while the count runs from cpu_len down to 1.
                    if (cpu_cnt == CNT_W'(1)) begin
                        cpu_cnt      <= '0;
                        o_cpu_window <= 1'b0;
                        state        <= StIdle;
                    end else begin
                        cpu_cnt <= cpu_cnt - CNT_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Testbench for dma_channel_arbiter.
// The stimulus thread drives inputs 2ns after each rising edge. It then advances a
// behavioural model of the arbiter and queues the outputs expected after the next edge.
// A separate monitor runs 1ns after every rising edge. It pops one expectation per cycle
// and compares it with the DUT outputs.
module tb_dma_channel_arbiter;

    logic        i_clk = 1'b0;
    logic        i_nrst = 1'b0;
    logic [6:0]  i_req = '0;
    logic [6:0]  i_master_en = '0;
    logic [20:0] i_priority = '1;
    logic [6:0]  i_chop_en = '0;
    logic [20:0] i_dma_win = '0;
    logic [20:0] i_cpu_win = '0;
    logic        i_word_ack = 1'b0;
    logic        i_ch_done = 1'b0;
    logic [6:0]  o_grant;
    logic [2:0]  o_grant_id;
    logic        o_bus_dma;
    logic        o_cpu_window;

    dma_channel_arbiter dut (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_req        (i_req),
        .i_master_en  (i_master_en),
        .i_priority   (i_priority),
        .i_chop_en    (i_chop_en),
        .i_dma_win    (i_dma_win),
        .i_cpu_win    (i_cpu_win),
        .i_word_ack   (i_word_ack),
        .i_ch_done    (i_ch_done),
        .o_grant      (o_grant),
        .o_grant_id   (o_grant_id),
        .o_bus_dma    (o_bus_dma),
        .o_cpu_window (o_cpu_window)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [6:0] grant;
        int         owner;
        logic       cpu;
    } exp_t;

    exp_t exp_q[$];

    int m_owner = -1;  // granted channel, -1 when none
    int m_burst = 0;   // words moved in the current burst
    int m_left  = 0;   // CPU window cycles still to run
    int m_ptr   = 6;   // last granted channel

    function automatic int prio_of(int k);
        return int'(i_priority[3*k +: 3]);
    endfunction

    function automatic int pick(logic [6:0] e);
        int best = 8;
        int w    = -1;
        for (int k = 0; k < 7; k++) if (e[k] && prio_of(k) < best) best = prio_of(k);
`ifdef DMA_ARB_ROUND_ROBIN_EN
        for (int o = 1; o <= 7; o++) begin
            int c;
            c = (m_ptr + o) % 7;
            if (w < 0 && e[c] && prio_of(c) == best) w = c;
        end
`else
        for (int k = 6; k >= 0; k--) if (w < 0 && e[k] && prio_of(k) == best) w = k;
`endif
        return w;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_burst = 0;
        m_left  = 0;
        m_ptr   = 6;
    endfunction

    function automatic void model_step();
        logic [6:0] e;
        exp_t       x;
        e = i_req & i_master_en;
        if (m_left > 0) begin
            m_left--;
        end else if (m_owner < 0) begin
            if (e != 0) begin
                m_owner = pick(e);
                m_burst = 0;
                m_ptr   = m_owner;
            end
        end else if (i_ch_done) begin
            m_owner = -1;
        end else if (!(i_req[m_owner] && i_master_en[m_owner])) begin
            m_owner = -1;
        end else if (i_word_ack) begin
            m_burst++;
            if (i_chop_en[m_owner] && m_burst == (1 << int'(i_dma_win[3*m_owner +: 3]))) begin
                m_left  = 1 << int'(i_cpu_win[3*m_owner +: 3]);
                m_owner = -1;
            end
        end
        x.owner = m_owner;
        x.grant = (m_owner >= 0) ? 7'(1 << m_owner) : 7'd0;
        x.cpu   = (m_left > 0);
        exp_q.push_back(x);
    endfunction

    // Evaluate the model with the inputs now applied, then move to 2ns after the next edge.
    task automatic step();
        model_step();
        @(posedge i_clk);
        #2;
    endtask

    // ---------------- monitor ----------------
    always @(posedge i_clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_grant", 32'(o_grant), 32'(e.grant));
            chk("sb_cpu_window", 32'(o_cpu_window), 32'(e.cpu));
            chk("sb_bus_dma", 32'(o_bus_dma), 32'(e.grant != 0));
            if (e.owner >= 0) chk("sb_grant_id", 32'(o_grant_id), 32'(e.owner));
        end
    end

    task automatic do_reset();
        i_nrst = 1'b0;
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge i_clk);
        #2;
        i_nrst = 1'b1;
    endtask

    task automatic set_ch(int k, int prio, logic chop, int dwin, int cwin);
        i_priority[3*k +: 3] = 3'(prio);
        i_chop_en[k]         = chop;
        i_dma_win[3*k +: 3]  = 3'(dwin);
        i_cpu_win[3*k +: 3]  = 3'(cwin);
    endtask

    task automatic pulse_done();
        i_ch_done = 1'b1;
        i_req     = '0;
        step();
        i_ch_done = 1'b0;
        step();
    endtask

    initial begin
        int n;
        do_reset();
        chk("reset_grant", 32'(o_grant), 0);
        chk("reset_grant_id", 32'(o_grant_id), 0);
        chk("reset_bus_dma", 32'(o_bus_dma), 0);
        chk("reset_cpu_window", 32'(o_cpu_window), 0);

        // Priority pick: ch2 (prio 1) beats ch4 (prio 3).
        i_master_en = 7'h7F;
        set_ch(2, 1, 1'b0, 0, 0);
        set_ch(4, 3, 1'b0, 0, 0);
        i_req = 7'b0010100;
        step();
        chk("pick_grant", 32'(o_grant), 32'h04);
        chk("pick_grant_id", 32'(o_grant_id), 2);
        pulse_done();

`ifndef DMA_ARB_ROUND_ROBIN_EN
        // Fixed tie: ch6 wins, then ch3 after an idle cycle.
        i_priority = '1;
        set_ch(0, 0, 1'b0, 0, 0);
        set_ch(3, 0, 1'b0, 0, 0);
        set_ch(6, 0, 1'b0, 0, 0);
        i_req = 7'b1001001;
        step();
        chk("tie_first", 32'(o_grant), 32'h40);
        i_ch_done = 1'b1;
        i_req     = 7'b0001001;
        step();
        i_ch_done = 1'b0;
        chk("tie_gap", 32'(o_grant), 0);
        step();
        chk("tie_second", 32'(o_grant), 32'h08);
        pulse_done();
`endif

        // Chopping: 4-word burst, then an 8-cycle CPU window, then ch2 again.
        i_priority = '1;
        set_ch(2, 1, 1'b1, 2, 3);
        i_req = 7'b0000100;
        step();
        for (int i = 0; i < 4; i++) begin
            i_word_ack = 1'b1;
            step();
            i_word_ack = 1'b0;
            if (i < 3) step();
        end
        chk("chop_window_on", 32'(o_cpu_window), 1);
        chk("chop_grant_off", 32'(o_grant), 0);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_cpu_window) n++;
            else break;
        end
        chk("chop_window_len", 32'(n), 8);
        step();
        chk("chop_regrant", 32'(o_grant), 32'h04);

        // Done on the 4th ack wins over the chop.
        for (int i = 0; i < 3; i++) begin
            i_word_ack = 1'b1;
            step();
        end
        i_ch_done = 1'b1;
        step();
        i_ch_done  = 1'b0;
        i_word_ack = 1'b0;
        i_req      = '0;
        chk("done_beats_chop_win", 32'(o_cpu_window), 0);
        chk("done_beats_chop_grant", 32'(o_grant), 0);
        step();
        chk("done_beats_chop_later", 32'(o_cpu_window), 0);

        // Abort by clearing the master enable.
        i_chop_en = '0;
        i_req     = 7'b0000100;
        step();
        chk("abort_granted", 32'(o_grant), 32'h04);
        i_master_en[2] = 1'b0;
        step();
        chk("abort_dropped", 32'(o_grant), 0);
        i_master_en = 7'h7F;
        i_req       = '0;
        step();

        // Asynchronous reset in the middle of a CPU window.
        set_ch(2, 1, 1'b1, 0, 3);
        i_req = 7'b0000100;
        step();
        i_word_ack = 1'b1;
        step();
        i_word_ack = 1'b0;
        step();
        chk("pre_reset_window", 32'(o_cpu_window), 1);
        #1;
        i_nrst = 1'b0;
        #1;
        chk("async_rst_grant", 32'(o_grant), 0);
        chk("async_rst_cpu_window", 32'(o_cpu_window), 0);
        chk("async_rst_bus_dma", 32'(o_bus_dma), 0);
        i_req = '0;
        do_reset();

        // Random traffic against the model, with the configuration held per batch.
        for (int b = 0; b < 25; b++) begin
            for (int k = 0; k < 7; k++)
                set_ch(k, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            for (int c = 0; c < 60; c++) begin
                for (int k = 0; k < 7; k++) begin
                    i_req[k]       = ($urandom_range(0, 2) != 0);
                    i_master_en[k] = ($urandom_range(0, 9) != 0);
                end
                i_word_ack = 1'($urandom_range(0, 1));
                i_ch_done  = ($urandom_range(0, 9) == 0);
                step();
            end
        end
        i_req      = '0;
        i_word_ack = 1'b0;
        i_ch_done  = 1'b0;
        step();

`ifdef DMA_ARB_ROUND_ROBIN_EN
        // Round-robin: ch1 and ch5 at equal priority alternate.
        do_reset();
        i_master_en = 7'h7F;
        i_priority  = '1;
        i_chop_en   = '0;
        set_ch(1, 2, 1'b0, 0, 0);
        set_ch(5, 2, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            i_req = 7'b0100010;
            step();
            chk("rr_grant_id", 32'(o_grant_id), (i % 2 == 0) ? 1 : 5);
            i_ch_done = 1'b1;
            step();
            i_ch_done = 1'b0;
        end
        i_req = '0;
        step();
`endif

        @(posedge i_clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_channel_arbiter.md
Name: dma_channel_arbiter

Overview:
- Bus scheduler for the 7-channel DMA controller (MDECin, MDECout, GPU, CDROM, SPU, PIO, OTC).
- Picks one requesting channel using the DPCR priority and master-enable fields and grants it the RAM bus.
- Enforces chopping windows: the granted channel runs a burst of DMA words, then the bus returns to the CPU for a fixed number of cycles.
- Sits between the channel register blocks and the shared RAM/bus mux.

Parameters:
- NCH, 7, number of channels; bit index = channel number.
- WIN_W, 3, width of each chopping window field; window length = 2^field.
- CNT_W, 8, width of the burst and CPU-window counters; must satisfy 2^CNT_W > 2^(2^WIN_W - 1).

Ports:
- i_clk  in  1  clock.
- i_nrst  in  1  asynchronous active-low reset.
- i_req  in  NCH  per-channel request: channel busy bit set AND DREQ (sync modes 1/2), or armed (sync mode 0).
- i_master_en  in  NCH  DPCR enable bits 3,7,...,27.
- i_priority  in  3*NCH  DPCR priority fields; channel k uses [3k+2:3k]; 0 is highest.
- i_chop_en  in  NCH  CHCR bit 8 per channel.
- i_dma_win  in  WIN_W*NCH  CHCR[18:16] per channel.
- i_cpu_win  in  WIN_W*NCH  CHCR[22:20] per channel.
- i_word_ack  in  1  granted channel completed one word transfer this cycle.
- i_ch_done  in  1  granted channel finished its whole transfer.
- o_grant  out  NCH  one-hot grant, registered.
- o_grant_id  out  3  binary id of the granted channel; valid only when o_bus_dma=1.
- o_bus_dma  out  1  the DMA owns the bus; equals |o_grant.
- o_cpu_window  out  1  chopping CPU window in progress.

Behaviour:
- Reset (asynchronous, i_nrst=0): state=IDLE; o_grant=0; o_grant_id=0; o_bus_dma=0; o_cpu_window=0; both counters=0.
- Eligible set: E = i_req & i_master_en.
- Winner: the channel in E with the numerically lowest priority. Ties go to the highest channel index.
- State IDLE:
  - If E≠0 at a clock edge: latch the winner into o_grant/o_grant_id; burst counter=0; go to GRANT.
  - Grant is visible in the cycle after the request is first sampled high (1-cycle latency).
- State GRANT, evaluated every edge in this priority order:
  - i_ch_done=1 → IDLE, grant cleared. Done beats a simultaneous i_word_ack and a simultaneous window end; no CPU window follows.
  - Granted channel's i_req or i_master_en is 0 (CPU abort) → IDLE, grant cleared. Word counts are not this block's concern.
  - i_word_ack=1: burst counter+1. If chop_en[g]=1 and the new count equals 2^dma_win[g]:
    - grant cleared;
    - CPU counter loaded with 2^cpu_win[g];
    - o_cpu_window=1;
    - go to CPU_WIN.
  - chop_en[g]=0: no burst limit; stay in GRANT until done or abort.
  - No preemption: a higher-priority request arriving during GRANT waits.
- State CPU_WIN:
  - CPU counter decrements every cycle. o_grant=0, o_bus_dma=0.
  - When the counter reaches 1 and is about to expire: o_cpu_window=0 at the next edge and the state goes to IDLE. CPU window length is exactly 2^cpu_win cycles.
  - Requests during CPU_WIN are ignored. Re-arbitration happens in IDLE, so the chopped channel competes again and may lose to another channel.
- Every grant change passes through at least one IDLE cycle with o_grant=0.
- Window and priority inputs are sampled live. Software must not change them for the granted channel while it is granted.
- The burst counter never wraps: maximum count is 2^7=128, which fits CNT_W=8.

Optional Feature:
- Macro: DMA_ARB_ROUND_ROBIN_EN.
- Defined: priority ties are broken round-robin.
  - A 3-bit last-grant pointer is reset to 6.
  - Among equal-priority eligible channels, the first index above the pointer (wrapping 6→0) wins.
  - The pointer updates on every IDLE→GRANT transition.
- Not defined: fixed tie-break, highest index wins. No pointer register exists.

Test Plan:
- Priority pick: reset; i_master_en=7'h7F; prio ch2=1, ch4=3; i_req=7'b0010100 → one cycle later o_grant=7'b0000100, o_grant_id=2.
- Fixed tie: ch0, ch3 and ch6 all prio 0 and requesting → grant ch6. Assert i_ch_done → o_grant=0 for ≥1 cycle, then grant ch3.
- Chopping: ch2 chop_en=1, dma_win=2, cpu_win=3; 4 i_word_ack pulses → o_grant=0 and o_cpu_window=1 for exactly 8 cycles → ch2 regranted.
- Done beats chop: on the 4th i_word_ack also assert i_ch_done → IDLE directly; o_cpu_window never rises.
- Abort and reset: clear i_master_en[2] mid-GRANT → grant drops next edge. Separately, pull i_nrst low mid-CPU_WIN → all outputs 0 immediately, without waiting for a clock edge.
- With DMA_ARB_ROUND_ROBIN_EN: ch1 and ch5 at equal priority, both requesting repeatedly with done after each grant → grants alternate 1,5,1,5.
